// File: rtl/conf_loader_if.sv
// Configuration word stream from the host/DMA side into conf_loader.
// Handshake: a word moves on a rising clk edge where conf_valid && conf_ready;
// the master may raise conf_valid without waiting for conf_ready, and must
// hold conf_addr/conf_data/conf_bcast/conf_last stable until that edge.
interface conf_loader_if #(
    parameter int ADDR_W = 6,
    parameter int CONF_W = 20
);
    logic              conf_valid;
    logic              conf_ready;
    logic [ADDR_W-1:0] conf_addr;
    logic [CONF_W-1:0] conf_data;
    logic              conf_bcast;
    logic              conf_last;

    modport master (
        output conf_valid, conf_addr, conf_data, conf_bcast, conf_last,
        input  conf_ready
    );

    modport slave (
        input  conf_valid, conf_addr, conf_data, conf_bcast, conf_last,
        output conf_ready
    );
endinterface

// File: rtl/conf_loader.sv
// Double-buffered PE configuration loader: words fill a shadow store, and a
// completed context is copied to the active store only while the array is idle.
module conf_loader #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int CONF_W = 20,
    parameter int ADDR_W = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    conf_loader_if.slave                conf,
    input  logic                        array_busy,
    output logic [ROWS*COLS*CONF_W-1:0] conf_out,
    output logic                        ctx_loaded,
    output logic                        swap_done,
    output logic                        err_addr,
    output logic [1:0]                  state_dbg
);
    localparam int NPE = ROWS * COLS;
    localparam logic [ADDR_W:0] NPE_A = (ADDR_W + 1)'(NPE);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PEND = 2'd2, SWAP = 2'd3} state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [NPE*CONF_W-1:0]    shadow_q;
    logic [NPE*CONF_W-1:0]    active_q;
    logic                     swap_done_q;
    logic                     err_addr_q;
    logic                     accepting;
    logic                     xfer;
    logic                     addr_ok;

    assign xfer    = conf.conf_valid && conf.conf_ready;
    assign addr_ok = ({1'b0, conf.conf_addr} < NPE_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, LOAD: begin
                if (xfer) begin
                    state_d = conf.conf_last ? PEND : LOAD;
                end
            end
            PEND: begin
                if (!array_busy) begin
                    state_d = SWAP;
                end
            end
            SWAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst_n so it drops the moment reset is asserted.
    always_comb begin
        accepting  = 1'b0;
        ctx_loaded = 1'b0;
        case (state_q)
            IDLE, LOAD: accepting  = 1'b1;
            PEND, SWAP: ctx_loaded = 1'b1;
            default: ;
        endcase
    end

    assign conf.conf_ready = accepting && rst_n;

    // Out-of-range addresses still complete the handshake but write nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (xfer) begin
            for (int i = 0; i < NPE; i++) begin
                if (conf.conf_bcast || (addr_ok && (conf.conf_addr == ADDR_W'(i)))) begin
                    shadow_q[i*CONF_W +: CONF_W] <= conf.conf_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= '0;
            swap_done_q <= 1'b0;
            err_addr_q  <= 1'b0;
        end else begin
            swap_done_q <= (state_q == SWAP);
            if (state_q == SWAP) begin
                active_q <= shadow_q;
            end
            if (xfer && !conf.conf_bcast && !addr_ok) begin
                err_addr_q <= 1'b1;
            end
        end
    end

    assign conf_out  = active_q;
    assign swap_done = swap_done_q;
    assign err_addr  = err_addr_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_conf_loader.sv
// Directed bench for conf_loader: a shadow model predicts each context and
// the expected active image is queued until the loader reports its swap.
module tb_conf_loader;
    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int CONF_W = 20;
    localparam int ADDR_W = 7;
    localparam int NPE    = ROWS * COLS;
    localparam int TOT    = NPE * CONF_W;

    logic           clk;
    logic           rst_n;
    logic           array_busy;
    logic [TOT-1:0] conf_out;
    logic           ctx_loaded;
    logic           swap_done;
    logic           err_addr;
    logic [1:0]     state_dbg;

    conf_loader_if #(.ADDR_W(ADDR_W), .CONF_W(CONF_W)) conf ();

    conf_loader #(.ROWS(ROWS), .COLS(COLS), .CONF_W(CONF_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .conf       (conf.slave),
        .array_busy (array_busy),
        .conf_out   (conf_out),
        .ctx_loaded (ctx_loaded),
        .swap_done  (swap_done),
        .err_addr   (err_addr),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [TOT-1:0] exp_q[$];
    logic [TOT-1:0] mdl_shadow;
    logic [TOT-1:0] mdl_active;
    logic           exp_err;
    int             n_checks;
    int             n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [TOT-1:0] obs, input logic [TOT-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void mdl_write(input int addr, input logic [CONF_W-1:0] data,
                                      input bit bcast, input bit last);
        if (bcast) begin
            for (int i = 0; i < NPE; i++) mdl_shadow[i*CONF_W +: CONF_W] = data;
        end else if (addr < NPE) begin
            mdl_shadow[addr*CONF_W +: CONF_W] = data;
        end else begin
            exp_err = 1'b1;
        end
        if (last) exp_q.push_back(mdl_shadow);
    endfunction

    // driver: entered and left at a falling edge; gaps = cycles of random valid before forcing it high
    task automatic send(input int addr, input logic [CONF_W-1:0] data,
                        input bit bcast, input bit last, input int gaps);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        conf.conf_addr  = ADDR_W'(addr);
        conf.conf_data  = data;
        conf.conf_bcast = bcast;
        conf.conf_last  = last;
        while (!done) begin
            conf.conf_valid = (n >= gaps) ? 1'b1 : 1'($urandom_range(0, 1));
            if (conf.conf_valid && conf.conf_ready) begin
                @(posedge clk);
                mdl_write(addr, data, bcast, last);
                done = 1'b1;
            end else if (n > 200) begin
                chk("send_timeout", 32'd1, 32'd0);
                done = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        conf.conf_valid = 1'b0;
        conf.conf_bcast = 1'b0;
        conf.conf_last  = 1'b0;
    endtask

    // waits for the swap pulse, checks latency, hold behaviour and the new image
    task automatic wait_swap(input int exp_lat);
        int n;
        n = 0;
        while (!swap_done && n < 100) begin
            chk("ready_low_pending", conf.conf_ready, 1'b0);
            chk_vec("conf_out_held", conf_out, mdl_active);
            @(negedge clk);
            n++;
        end
        chk("swap_latency", n, exp_lat);
        if (swap_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_swap", 32'd1, 32'd0);
            end else begin
                mdl_active = exp_q.pop_front();
                chk_vec("conf_out_swap", conf_out, mdl_active);
            end
        end
        chk("err_addr", err_addr, exp_err);
        @(negedge clk);
        chk("swap_pulse_one_cycle", swap_done, 1'b0);
        chk("ready_after_swap", conf.conf_ready, 1'b1);
    endtask

    initial begin
        n_checks        = 0;
        n_err           = 0;
        mdl_shadow      = '0;
        mdl_active      = '0;
        exp_err         = 1'b0;
        rst_n           = 1'b0;
        array_busy      = 1'b0;
        conf.conf_valid = 1'b0;
        conf.conf_addr  = '0;
        conf.conf_data  = '0;
        conf.conf_bcast = 1'b0;
        conf.conf_last  = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk_vec("reset_conf_out", conf_out, '0);
        chk("reset_flags", {26'd0, conf.conf_ready, ctx_loaded, swap_done, err_addr, state_dbg}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", conf.conf_ready, 1'b1);

        // full context, data = addr+1, minimum latency
        for (int i = 0; i < NPE; i++) send(i, CONF_W'(i + 1), 1'b0, (i == NPE - 1), 0);
        chk("ctx_loaded_pend", ctx_loaded, 1'b1);
        wait_swap(2);
        chk("slice0", conf_out[0 +: CONF_W], 32'd1);
        chk("slice63", conf_out[63*CONF_W +: CONF_W], 32'd64);

        // busy defers the swap; stray valid during PEND must not be taken
        array_busy = 1'b1;
        for (int i = 0; i < 5; i++)
            send($urandom_range(0, NPE - 1), CONF_W'($urandom_range(0, 20'hFFFFF)), 1'b0, (i == 4), 0);
        conf.conf_addr  = ADDR_W'(7);
        conf.conf_data  = 20'hFFFFF;
        conf.conf_valid = 1'b1;
        repeat (3) begin
            chk("ready_low_in_pend", conf.conf_ready, 1'b0);
            @(negedge clk);
        end
        conf.conf_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("busy_hold", {conf.conf_ready, ctx_loaded, swap_done, (conf_out !== mdl_active)}, 32'b0100);
            @(negedge clk);
        end
        array_busy = 1'b0;
        wait_swap(2);

        // broadcast context, then an incremental one touching only PE 9
        send(0, 20'h5A5A5, 1'b1, 1'b1, 0);
        wait_swap(2);
        send(9, 20'h00001, 1'b0, 1'b1, 0);
        wait_swap(2);
        chk("bcast_slice9", conf_out[9*CONF_W +: CONF_W], 32'h00001);
        chk("bcast_slice8", conf_out[8*CONF_W +: CONF_W], 32'h5A5A5);
        chk("bcast_slice63", conf_out[63*CONF_W +: CONF_W], 32'h5A5A5);

        // out-of-range address: accepted, ignored, sticky flag
        chk("err_before", err_addr, 1'b0);
        send(64, 20'hABCDE, 1'b0, 1'b0, 0);
        chk("err_set", err_addr, 1'b1);
        send(3, 20'h12345, 1'b0, 1'b1, 0);
        wait_swap(2);
        chk("err_slice3", conf_out[3*CONF_W +: CONF_W], 32'h12345);
        send(127, 20'h0BEEF, 1'b0, 1'b1, 0);
        wait_swap(2);
        chk("err_sticky", err_addr, 1'b1);

        // random valid toggling with stable data
        for (int i = 0; i < 20; i++)
            send($urandom_range(0, NPE - 1), CONF_W'($urandom_range(0, 20'hFFFFF)), 1'b0,
                 (i == 19), $urandom_range(0, 3));
        wait_swap(2);

        // asynchronous reset mid-load discards the partial context
        for (int i = 0; i < 6; i++) send(20 + i, CONF_W'($urandom_range(1, 20'hFFFFF)), 1'b0, 1'b0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_vec("async_reset_conf_out", conf_out, '0);
        chk("async_reset_flags", {26'd0, conf.conf_ready, ctx_loaded, swap_done, err_addr, state_dbg}, 32'd0);
        mdl_shadow = '0;
        mdl_active = '0;
        exp_err    = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 10; i < 18; i++) send(i, CONF_W'($urandom_range(0, 20'hFFFFF)), 1'b0, (i == 17), 0);
        wait_swap(2);
        chk("post_reset_slice20", conf_out[20*CONF_W +: CONF_W], 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/conf_loader.md
Name: conf_loader

Overview:
- Writer side of the PE configuration interface: accepts per-PE configuration words over a valid/ready stream and drives the active CONF_ALU/CONF_SEL/CONF_SE field vectors of a ROWS×COLS PE array.
- Double-buffered: words land in a shadow store; a full context swaps into the active store in one cycle, but only while the array is not busy.
- Sits between the host/DMA configuration stream and the PE array top level. Neighbour fields (_N/_NE/_NW) are sliced from CONF_OUT by the array wiring, not by this block.

Parameters:
- ROWS, 8, PE rows.
- COLS, 8, PE columns.
- CONF_W, 20, bits per PE: {ALU, SEL_A, SEL_B, SE} packed MSB to LSB.
- ADDR_W, 6, PE index width; must be ≥ clog2(ROWS*COLS).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CONF_VALID  in  1  configuration word offered.
- CONF_READY  out  1  loader can accept a word.
- CONF_ADDR  in  ADDR_W  PE index = row*COLS+col.
- CONF_DATA  in  CONF_W  configuration word for that PE.
- CONF_BCAST  in  1  write CONF_DATA to every PE; CONF_ADDR is ignored.
- CONF_LAST  in  1  last word of the current context.
- ARRAY_BUSY  in  1  array executing; swap is deferred while high.
- CONF_OUT  out  ROWS*COLS*CONF_W  active config; PE i at [i*CONF_W +: CONF_W].
- CTX_LOADED  out  1  shadow complete, waiting for swap.
- SWAP_DONE  out  1  one-cycle pulse; new CONF_OUT valid this cycle.
- ERR_ADDR  out  1  sticky out-of-range address flag.

Behaviour:
- Reset (RST_N low, asynchronous): shadow and active stores all zero (zero = ALU NOP, all switches off); CONF_OUT=0, CONF_READY=0, CTX_LOADED=0, SWAP_DONE=0, ERR_ADDR=0; FSM to IDLE. Reset mid-load discards the partial context.
- Transfer: occurs on a rising edge with CONF_VALID & CONF_READY. CONF_VALID is not required to wait for CONF_READY. Stimulus must hold ADDR/DATA/BCAST/LAST stable while VALID is high and not accepted.
- FSM states: IDLE, LOAD, PEND, SWAP.
- IDLE: CONF_READY=1.
  - Accepted word with LAST=0: write shadow, go to LOAD.
  - Accepted word with LAST=1: write shadow, go to PEND.
- LOAD: CONF_READY=1; same write rules; LAST=1 goes to PEND.
- PEND: CONF_READY=0, CTX_LOADED=1. ARRAY_BUSY is sampled each cycle; when low, go to SWAP at the next edge.
- SWAP: one cycle, CONF_READY=0, CTX_LOADED=1. At its closing edge: active ← shadow, SWAP_DONE ← 1, go to IDLE. SWAP_DONE is registered and high exactly one cycle. ARRAY_BUSY is ignored in SWAP; a swap, once entered, completes.
- Minimum latency: LAST accepted at edge k, BUSY low → CONF_OUT updated and SWAP_DONE high after edge k+2.
- Shadow write rules:
  - Shadow is not cleared between contexts; unwritten PEs keep their previous shadow value, which gives incremental reconfiguration.
  - BCAST writes all ROWS*COLS entries in the same edge.
  - BCAST with LAST is legal: broadcast, then PEND.
- Address error: CONF_ADDR ≥ ROWS*COLS with BCAST=0 → word accepted (handshake completes), no shadow write, ERR_ADDR set. ERR_ADDR is cleared only by reset. A LAST on an erroneous word still ends the context.
- Active store changes only in SWAP, so CONF_OUT is glitch-free to the combinational PE datapath.

Test Plan:
- Reset, then write addr 0..63 with DATA=addr+1, LAST on 63, BUSY=0 → CONF_OUT slice i = i+1 after edge k+2; SWAP_DONE high one cycle; READY low for exactly 2 cycles.
- Load a context with BUSY=1 held 10 cycles after LAST → CTX_LOADED=1, READY=0, CONF_OUT unchanged for 10 cycles; swap 2 edges after BUSY falls.
- BCAST DATA=0x5A5A5 with LAST, then a second context writing only addr 9 = 0x00001 → after the 2nd swap, slice 9 = 0x00001 and all others = 0x5A5A5.
- Word at addr 64 (8×8) followed by LAST at addr 3 = 0x12345 → ERR_ADDR=1 sticky, no entry corrupted, slice 3 = 0x12345.
- VALID toggled randomly with stable data during LOAD → each word written exactly once; no writes in PEND/SWAP.
- RST_N asserted asynchronously mid-LOAD (between edges) → all outputs zero immediately; a subsequent full context loads cleanly.
